// File: rtl/fb_write_arbiter.sv
// Round-robin owner of frame_buffer's pixel-write port; a client may burst up to MAX_BURST grants while others wait.
// Latency: fb_req rises two edges after cl_req is sampled; no pixel is accepted while fb_busy is high or a write is in flight.
module fb_write_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int PIXEL_WIDTH = 16,
    parameter int MAX_BURST   = 4,
    localparam int ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NUM_CLIENTS-1:0]             cl_req,
    input  logic [NUM_CLIENTS*16-1:0]          cl_x,
    input  logic [NUM_CLIENTS*16-1:0]          cl_y,
    input  logic [NUM_CLIENTS*PIXEL_WIDTH-1:0] cl_pixel,
    output logic [NUM_CLIENTS-1:0]             cl_resp,
    output logic                               fb_req,
    output logic [15:0]                        fb_x,
    output logic [15:0]                        fb_y,
    output logic [PIXEL_WIDTH-1:0]             fb_pixel,
    input  logic                               fb_resp,
    input  logic                               fb_busy,
    output logic [ID_W-1:0]                    grant_id,
    output logic                               arb_busy
);

    localparam int BCNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic                   do_grant, do_done;
    logic [ID_W-1:0]        rr_ptr;
    logic [BCNT_W-1:0]      burst_cnt;
    logic [ID_W-1:0]        rr_id, win_id;
    logic                   rr_hit, owner_keeps;
    logic [2*NUM_CLIENTS-1:0] req_rot;
    int                     rr_sum;
    logic [15:0]            sel_x, sel_y;
    logic [PIXEL_WIDTH-1:0] sel_pix;

    // Requests rotated so bit k corresponds to client (rr_ptr + k) mod NUM_CLIENTS.
    assign req_rot = {cl_req, cl_req} >> rr_ptr;

    always_comb begin
        rr_id  = '0;
        rr_hit = 1'b0;
        rr_sum = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!rr_hit && req_rot[k]) begin
                rr_hit = 1'b1;
                rr_sum = int'(rr_ptr) + k;
                if (rr_sum >= NUM_CLIENTS) begin
                    rr_sum = rr_sum - NUM_CLIENTS;
                end
                rr_id = ID_W'(rr_sum);
            end
        end
    end

    assign owner_keeps = (|(cl_req & (NUM_CLIENTS'(1) << grant_id)))
                         && (burst_cnt < BCNT_W'(MAX_BURST));
    assign win_id      = owner_keeps ? grant_id : rr_id;

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_pix = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_x   = cl_x[i*16 +: 16];
                sel_y   = cl_y[i*16 +: 16];
                sel_pix = cl_pixel[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|cl_req) && !fb_busy) begin
                    do_grant = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (fb_resp) begin
                    do_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            fb_req    <= 1'b0;
            fb_x      <= '0;
            fb_y      <= '0;
            fb_pixel  <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (do_grant) begin
                fb_x     <= sel_x;
                fb_y     <= sel_y;
                fb_pixel <= sel_pix;
                grant_id <= win_id;
                // Saturating run length of the current owner; a new owner restarts at one.
                if (win_id != grant_id) begin
                    burst_cnt <= BCNT_W'(1);
                end else if (burst_cnt < BCNT_W'(MAX_BURST)) begin
                    burst_cnt <= burst_cnt + BCNT_W'(1);
                end
            end
            if (state_q == S_ISSUE) begin
                fb_req <= 1'b1;
            end
            if (do_done) begin
                fb_req   <= 1'b0;
                fb_x     <= '0;
                fb_y     <= '0;
                fb_pixel <= '0;
                rr_ptr   <= (grant_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    assign cl_resp  = (state_q == S_WAIT && fb_resp) ? (NUM_CLIENTS'(1) << grant_id) : '0;
    assign arb_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench: client stubs and a frame_buffer stub driven mid-cycle; expected write order is queued up front
// and each cl_resp pulse pops and compares the owner, coordinates and pixel.
module tb_fb_write_arbiter;

    localparam int NC = 3;
    localparam int PW = 16;
    localparam int MB = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] p;
    } exp_t;

    logic              aclk;
    logic              aresetn;
    logic [NC-1:0]     cl_req;
    logic [NC*16-1:0]  cl_x;
    logic [NC*16-1:0]  cl_y;
    logic [NC*PW-1:0]  cl_pixel;
    logic [NC-1:0]     cl_resp;
    logic              fb_req;
    logic [15:0]       fb_x;
    logic [15:0]       fb_y;
    logic [PW-1:0]     fb_pixel;
    logic              fb_resp;
    logic              fb_busy;
    logic [1:0]        grant_id;
    logic              arb_busy;

    logic [47:0] cmem [NC][32];
    int          ccnt [NC];
    int          cidx [NC];
    exp_t        exp_q [$];
    int          fb_lat;
    int          wcnt;
    int          nresp;
    int          chk_cnt;
    int          err_cnt;

    fb_write_arbiter #(
        .NUM_CLIENTS(NC),
        .PIXEL_WIDTH(PW),
        .MAX_BURST  (MB)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .cl_req   (cl_req),
        .cl_x     (cl_x),
        .cl_y     (cl_y),
        .cl_pixel (cl_pixel),
        .cl_resp  (cl_resp),
        .fb_req   (fb_req),
        .fb_x     (fb_x),
        .fb_y     (fb_y),
        .fb_pixel (fb_pixel),
        .fb_resp  (fb_resp),
        .fb_busy  (fb_busy),
        .grant_id (grant_id),
        .arb_busy (arb_busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", err_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] px(input int c, input int k);
        return {16'(c * 256 + k), 16'(16'h0040 + k), 16'(16'hA000 + c * 16 + k)};
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < NC; i++) begin
            if (cidx[i] < ccnt[i]) begin
                cl_req[i]            = 1'b1;
                cl_x[i*16 +: 16]     = cmem[i][cidx[i]][47:32];
                cl_y[i*16 +: 16]     = cmem[i][cidx[i]][31:16];
                cl_pixel[i*PW +: PW] = cmem[i][cidx[i]][15:0];
            end else begin
                cl_req[i] = 1'b0;
            end
        end
    endtask

    task automatic load(input int c, input logic [47:0] d);
        cmem[c][ccnt[c]] = d;
        ccnt[c]++;
        drive_clients();
    endtask

    task automatic push_exp(input int c, input logic [47:0] d);
        exp_t e;
        e.id = 2'(c);
        e.x  = d[47:32];
        e.y  = d[31:16];
        e.p  = d[15:0];
        exp_q.push_back(e);
    endtask

    // One clock: frame_buffer stub reacts at the falling edge, outputs are inspected 1ns later.
    task automatic cycle();
        exp_t e;
        @(negedge aclk);
        if (fb_req && aresetn) begin
            if (wcnt >= fb_lat) begin
                fb_resp = 1'b1;
                wcnt    = 0;
            end else begin
                fb_resp = 1'b0;
                wcnt++;
            end
        end else begin
            fb_resp = 1'b0;
            wcnt    = 0;
        end
        #1;
        if (cl_resp != '0) begin
            nresp++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_resp", 64'(cl_resp), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("resp_vec", 64'(cl_resp), 64'(1) << e.id);
                check_eq("grant_id", 64'(grant_id), 64'(e.id));
                check_eq("fb_x", 64'(fb_x), 64'(e.x));
                check_eq("fb_y", 64'(fb_y), 64'(e.y));
                check_eq("fb_pixel", 64'(fb_pixel), 64'(e.p));
            end
            for (int i = 0; i < NC; i++) begin
                if (cl_resp[i]) cidx[i]++;
            end
            drive_clients();
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fb_req) && n < budget) begin
            cycle();
            n++;
        end
        check_eq("drained_queue", 64'(exp_q.size()), 64'(0));
        check_eq("drained_fb_req", 64'(fb_req), 64'(0));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        fb_resp = 1'b0;
        wcnt    = 0;
        cycle();
        cycle();
        aresetn = 1'b1;
        cycle();
    endtask

    initial begin
        int base;
        int n;
        chk_cnt  = 0;
        err_cnt  = 0;
        nresp    = 0;
        wcnt     = 0;
        fb_lat   = 2;
        fb_busy  = 1'b0;
        fb_resp  = 1'b0;
        cl_req   = '0;
        cl_x     = '0;
        cl_y     = '0;
        cl_pixel = '0;
        for (int i = 0; i < NC; i++) begin
            ccnt[i] = 0;
            cidx[i] = 0;
        end
        aresetn = 1'b0;
        cycle();
        cycle();
        check_eq("rst_fb_req", 64'(fb_req), 64'(0));
        check_eq("rst_cl_resp", 64'(cl_resp), 64'(0));
        check_eq("rst_grant_id", 64'(grant_id), 64'(0));
        check_eq("rst_arb_busy", 64'(arb_busy), 64'(0));
        check_eq("rst_fb_xy", 64'({fb_x, fb_y, fb_pixel}), 64'(0));
        aresetn = 1'b1;
        cycle();

        // Single write: fb_req appears two edges after the request is first sampled.
        base = nresp;
        load(0, {16'h00EC, 16'h0082, 16'hA108});
        push_exp(0, {16'h00EC, 16'h0082, 16'hA108});
        cycle();
        check_eq("single_req_edge1", 64'(fb_req), 64'(0));
        check_eq("single_busy_edge1", 64'(arb_busy), 64'(1));
        cycle();
        check_eq("single_req_edge2", 64'(fb_req), 64'(1));
        check_eq("single_x", 64'(fb_x), 64'h00EC);
        check_eq("single_y", 64'(fb_y), 64'h0082);
        check_eq("single_pix", 64'(fb_pixel), 64'hA108);
        drain(50);
        check_eq("single_resp_count", 64'(nresp - base), 64'(1));
        check_eq("single_x_cleared", 64'(fb_x), 64'(0));

        // Simultaneous requests from clients 0 and 1.
        fb_lat = 1;
        load(0, {16'h0011, 16'h0021, 16'h1111});
        load(1, {16'h0012, 16'h0022, 16'h2222});
        push_exp(0, {16'h0011, 16'h0021, 16'h1111});
        push_exp(1, {16'h0012, 16'h0022, 16'h2222});
        drain(50);

        // Burst fairness from a clean reset: 0,0,0,0,1,0,0.
        do_reset();
        fb_lat = 0;
        for (int k = 0; k < 6; k++) load(0, px(0, 16 + k));
        load(1, px(1, 16));
        for (int k = 0; k < 4; k++) push_exp(0, px(0, 16 + k));
        push_exp(1, px(1, 16));
        push_exp(0, px(0, 20));
        push_exp(0, px(0, 21));
        drain(100);

        // Lone burst of 8: three cycles per pixel with zero frame_buffer latency.
        base = nresp;
        for (int k = 0; k < 8; k++) begin
            load(0, px(0, 32 + k));
            push_exp(0, px(0, 32 + k));
        end
        n = 0;
        while (nresp - base < 8 && n < 100) begin
            cycle();
            n++;
        end
        check_eq("lone_burst_cycles", 64'(n), 64'(23));
        drain(20);

        // fb_busy holds off every grant.
        fb_lat  = 1;
        fb_busy = 1'b1;
        load(1, px(1, 48));
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_eq("busy_no_req", 64'({fb_req, arb_busy}), 64'(0));
        end
        fb_busy = 1'b0;
        push_exp(1, px(1, 48));
        cycle();
        check_eq("busy_release_grant", 64'(arb_busy), 64'(1));
        drain(50);

        // Reset in WAIT abandons the write; client1 is then served normally.
        fb_lat = 20;
        load(2, px(2, 64));
        push_exp(2, px(2, 64));
        n = 0;
        while (!fb_req && n < 10) begin
            cycle();
            n++;
        end
        check_eq("midrst_in_wait", 64'({fb_req, grant_id}), 64'({1'b1, 2'd2}));
        load(1, px(1, 65));
        aresetn = 1'b0;
        #1;
        check_eq("midrst_fb_req", 64'(fb_req), 64'(0));
        check_eq("midrst_cl_resp", 64'(cl_resp), 64'(0));
        check_eq("midrst_grant_id", 64'(grant_id), 64'(0));
        check_eq("midrst_arb_busy", 64'(arb_busy), 64'(0));
        cidx[2] = ccnt[2];
        drive_clients();
        exp_q.delete();
        fb_resp = 1'b0;
        wcnt    = 0;
        base    = nresp;
        cycle();
        check_eq("midrst_no_pulse", 64'(nresp - base), 64'(0));
        aresetn = 1'b1;
        fb_lat  = 1;
        push_exp(1, px(1, 65));
        drain(50);
        check_eq("midrst_one_resp", 64'(nresp - base), 64'(1));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Round-robin arbiter that shares the single pixel-write port of frame_buffer between NUM_CLIENTS pixel producers (cel engine, fill/clear engine, debug writer).
- Latches the winning client's x/y/pixel and drives frame_buffer's req/resp handshake.
- Returns the response to the winning client.
- Supports bounded back-to-back bursts per client, so consecutive span pixels stay ordered without starving other clients.

Parameters:
- NUM_CLIENTS, 2, number of requesters (2..8).
- PIXEL_WIDTH, 16, pixel width, matching frame_buffer PIXEL_WIDTH.
- MAX_BURST, 4, maximum consecutive grants to one client while others are waiting (1..255).
- ID_W, max(1,$clog2(NUM_CLIENTS)), grant index width (derived, not overridden).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cl_req  in  NUM_CLIENTS  per-client write request, held until matching cl_resp.
- cl_x  in  NUM_CLIENTS*16  per-client x coordinate.
- cl_y  in  NUM_CLIENTS*16  per-client y coordinate.
- cl_pixel  in  NUM_CLIENTS*PIXEL_WIDTH  per-client pixel value.
- cl_resp  out  NUM_CLIENTS  one-cycle completion pulse to the granted client.
- fb_req  out  1  request to frame_buffer.req.
- fb_x  out  16  to frame_buffer.x.
- fb_y  out  16  to frame_buffer.y.
- fb_pixel  out  PIXEL_WIDTH  to frame_buffer.pixel.
- fb_resp  in  1  from frame_buffer.resp, one-cycle pulse.
- fb_busy  in  1  from frame_buffer.busy.
- grant_id  out  ID_W  index of current or last owner.
- arb_busy  out  1  high in ISSUE and WAIT states.

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE.
  - fb_req, fb_x, fb_y, fb_pixel = 0; cl_resp = 0; grant_id = 0; arb_busy = 0.
  - rr_ptr = 0; burst_cnt = 0.
  - Reset mid-transaction abandons it; no cl_resp is issued. frame_buffer shares aresetn.
- IDLE:
  - At a posedge with any cl_req high and fb_busy=0, pick the winner.
  - If the previous owner still has cl_req high, burst_cnt<MAX_BURST and that owner is not the only... (any other requester) case: the previous owner wins when burst_cnt<MAX_BURST; otherwise the first requesting index searching upward from rr_ptr, with wrap-around.
  - Latch the winner's cl_x/cl_y/cl_pixel into fb_x/fb_y/fb_pixel, set grant_id, go to ISSUE.
  - fb_busy=1 blocks all grants.
- ISSUE:
  - fb_req=1 (registered, so first asserted the cycle after the sampling edge). Go to WAIT next edge.
  - fb_x/fb_y/fb_pixel stay stable until the response.
- WAIT:
  - fb_req stays 1 until a posedge samples fb_resp=1.
  - cl_resp[grant_id] = fb_resp, combinational AND of the WAIT state and fb_resp; other cl_resp bits stay 0.
  - On that edge: fb_req<=0, fb_x/fb_y/fb_pixel<=0, rr_ptr<=grant_id+1 (wrapping mod NUM_CLIENTS), go to IDLE.
  - fb_resp in IDLE or ISSUE is ignored.
- Turnaround: IDLE is always one full cycle after each response, so the client can present its next pixel before it is sampled. Minimum of 3 cycles per pixel plus frame_buffer latency.
- Burst count:
  - burst_cnt increments when the same owner is re-granted; it resets to 1 on a grant to a different client.
  - If no other client is requesting, the owner keeps winning regardless of burst_cnt; burst_cnt saturates at MAX_BURST.
- A client that drops cl_req while granted does not abort the transaction: the latched write completes and cl_resp still pulses.
- fb_busy rising during WAIT has no effect on the in-flight write.

Test Plan:
- Single write: after reset, client0 requests x=0xEC, y=0x82, pixel=0xA108 → fb_req rises 2 edges later with fb_x=0x00EC, fb_y=0x0082, fb_pixel=0xA108. On fb_resp, cl_resp[0] is a single one-cycle pulse and fb_req drops the same edge.
- Simultaneous requests: clients 0 and 1 both request at the first edge → grant order is 0 then 1. cl_resp pulses go only to the matching index, and each fb_x matches its owner's value.
- Burst fairness (MAX_BURST=4): client0 streams 6 pixels while client1 holds a request → grant_id sequence is 0,0,0,0,1,0,0.
- Lone burst: client0 streams 8 pixels with no other requester → 8 consecutive grants to 0 and no idle stalls beyond the one IDLE cycle per pixel.
- fb_busy: hold fb_busy=1 for 10 cycles with client1 requesting → fb_req stays 0. Grant happens on the first edge with fb_busy=0.
- Reset mid-transaction: drop aresetn during WAIT → fb_req=0 and cl_resp=0 immediately. After release, grant_id=0 and rr_ptr=0, and a pending request from client1 is granted normally.
